// File: rtl/fetch_redirect_unit_pkg.sv
// Shared definitions for the IF-stage fetch/redirect logic: widths, the NOP
// encoding and the fetch FSM state type.
package fetch_redirect_unit_pkg;

  localparam int          DEF_XLEN  = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    ST_FETCH  = 1'b0,
    ST_SQUASH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_unit_fetch_buffer.sv
// DEPTH-entry FIFO of {pc, instr} between imem responses and the IF/ID register.
// Clear has priority over push and pop.
module fetch_redirect_unit_fetch_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [XLEN-1:0]          push_pc,
  input  logic [31:0]              push_instr,
  output logic [XLEN-1:0]          head_pc,
  output logic [31:0]              head_instr,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] r_pc    [DEPTH];
  logic [31:0]     r_instr [DEPTH];
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_wr;
  logic [CW-1:0]   r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wr <= r_wr + AW'(1);
      if (pop)  r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      r_pc[r_wr]    <= push_pc;
      r_instr[r_wr] <= push_instr;
    end
  end

  assign head_pc    = r_pc[r_rd];
  assign head_instr = r_instr[r_rd];
  assign full       = (r_count == CW'(DEPTH));
  assign empty      = (r_count == '0);
  assign count      = r_count;

endmodule

// File: rtl/fetch_redirect_unit.sv
// IF-stage PC owner: issues imem requests, buffers responses toward ID and
// squashes wrong-path fetches when EX redirects.
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter int              XLEN      = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            stall_if,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            dbg_state
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  // imem request: valid/ready; a request transfers on the cycle both are high,
  // addr/valid hold until then, and only a redirect may drop an unaccepted one.

  fetch_state_e    r_state, w_state_nxt;
  logic            r_out, w_out_nxt;
  logic [XLEN-1:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [XLEN-1:0] r_out_pc;

  logic            w_empty, w_full;
  logic [CW-1:0]   w_count;
  logic [XLEN-1:0] w_head_pc;
  logic [31:0]     w_head_instr;
  logic            w_rsp_live, w_req_valid, w_req_fire;
  logic            w_show, w_pop, w_push;
  logic            w_unused_tgt_lsb;

  assign w_unused_tgt_lsb = ^br_target[1:0];

  // A response on the live path is shown the same cycle when the buffer is
  // empty (bypass), so a 1-cycle imem gives one instruction per cycle.
  // A new request may overlap an outstanding one only in the cycle its
  // response returns, which keeps at most one request in flight.
  always_comb begin
    w_rsp_live  = imem_rsp_valid && r_out && (r_state == ST_FETCH) && !br_taken;
    w_req_valid = rst_n && (r_state == ST_FETCH) && !br_taken
                  && (!r_out || imem_rsp_valid)
                  && ((int'(w_count) + int'(r_out)) < BUF_DEPTH);
    w_req_fire  = w_req_valid && imem_req_ready;
    w_show      = !br_taken && (!w_empty || w_rsp_live);
    w_pop       = w_show && !stall_if && !w_empty;
    w_push      = w_rsp_live && !(w_empty && !stall_if) && (!w_full || w_pop);
  end

  // A redirect in SQUASH that coincides with the stale response retires the
  // squash at once; otherwise the stale response is still owed.
  always_comb begin
    w_state_nxt    = r_state;
    w_out_nxt      = r_out;
    w_fetch_pc_nxt = r_fetch_pc;
    if (imem_rsp_valid && r_out) w_out_nxt = 1'b0;
    if (w_req_fire) begin
      w_out_nxt      = 1'b1;
      w_fetch_pc_nxt = r_fetch_pc + XLEN'(4);
    end
    case (r_state)
      ST_FETCH:  if (br_taken && r_out && !imem_rsp_valid) w_state_nxt = ST_SQUASH;
      ST_SQUASH: if (imem_rsp_valid) w_state_nxt = ST_FETCH;
      default:   w_state_nxt = ST_FETCH;
    endcase
    if (br_taken) w_fetch_pc_nxt = {br_target[XLEN-1:2], 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_FETCH;
      r_out      <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_out_pc   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_out      <= w_out_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      if (w_req_fire) r_out_pc <= r_fetch_pc;
    end
  end

  fetch_redirect_unit_fetch_buffer #(
    .XLEN  (XLEN),
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (w_push),
    .pop        (w_pop),
    .clear      (br_taken),
    .push_pc    (r_out_pc),
    .push_instr (imem_rsp_data),
    .head_pc    (w_head_pc),
    .head_instr (w_head_instr),
    .full       (w_full),
    .empty      (w_empty),
    .count      (w_count)
  );

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign if_valid       = w_show;
  assign if_pc          = !w_show ? '0 : (w_empty ? r_out_pc : w_head_pc);
  assign if_instr       = !w_show ? NOP_INSTR : (w_empty ? imem_rsp_data : w_head_instr);
  assign flush_ifid     = br_taken;
  assign flush_idex     = br_taken;
  assign dbg_state      = r_state;

endmodule
